uart_word_initiator: RTL and testbench
======================================

UART_WORD_INITIATOR -- requirements
Module: uart_word_initiator

Interface
REQ-001 SHALL have parameter DBITS, default 8: data bits per UART frame.
REQ-002 SHALL have parameter SB_TICK, default 16: stop-bit length in oversampling ticks.
REQ-003 SHALL have parameter BR_LIMIT, default 14: clock cycles per oversampling tick.
REQ-004 SHALL have parameter BR_BITS, default $clog2(BR_LIMIT): baud counter width.
REQ-005 SHALL have parameter REQ_BYTES, default 4: bytes per request.
REQ-006 SHALL have parameter RESP_BYTES, default 4: bytes per response.
REQ-007 SHALL have parameter TIMEOUT_TICKS, default 65535: allowed idle ticks while waiting for a response byte.
REQ-008 SHALL have port clk_100MHz, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-010 SHALL have port start, input, 1 bit: request launch strobe.
REQ-011 SHALL have port req_data, input, DBITS*REQ_BYTES bits: request word, sampled when start is accepted.
REQ-012 SHALL have port tx, output, 1 bit: serial line out, idle high.
REQ-013 SHALL have port rx, input, 1 bit: serial line in, idle high.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port resp_valid, output, 1 bit: one-cycle pulse when the response is complete.
REQ-016 SHALL have port resp_data, output, DBITS*RESP_BYTES bits: last complete response.
REQ-017 SHALL have port timeout, output, 1 bit: one-cycle pulse when the response wait expires.

Function
REQ-018 Baud tick SHALL pulse for one cycle every BR_LIMIT cycles; its counter runs 0..BR_LIMIT-1 and ticks at BR_LIMIT-1.
REQ-019 The FSM SHALL have states IDLE, SEND, WAIT_RESP and DONE.
REQ-020 IDLE: start=1 SHALL latch req_data, clear byte and timeout counters, and go to SEND; busy rises on the next cycle.
REQ-021 start SHALL be ignored while busy=1.
REQ-022 SEND: bytes SHALL go out most-significant byte first, as back-to-back 8N1 frames.
REQ-023 Frame format: start bit low 16 ticks; DBITS data bits LSB-first, 16 ticks each; stop bit high SB_TICK ticks.
REQ-024 No idle gap SHALL occur between frames; after byte REQ_BYTES-1's stop bit the FSM goes to WAIT_RESP.
REQ-025 RX SHALL detect start on a falling edge of rx, confirm it low at tick 7, then sample each data bit every 16 ticks thereafter.
REQ-026 A received byte SHALL shift in as shreg <= (shreg << DBITS) | byte, so the first byte ends in the MS byte.
REQ-027 RX bytes arriving in IDLE or SEND SHALL be discarded; the RX shift register is cleared on entry to WAIT_RESP.
REQ-028 WAIT_RESP: the timeout counter SHALL increment per tick, reset to 0 when each byte completes, and saturate.
REQ-029 WAIT_RESP: reaching TIMEOUT_TICKS SHALL pulse timeout, return to IDLE, and leave resp_data unchanged.
REQ-030 WAIT_RESP: when RESP_BYTES bytes are received the FSM SHALL go to DONE, copying shreg to resp_data in the same edge.
REQ-031 DONE SHALL last exactly one cycle, assert resp_valid, then return to IDLE.
REQ-032 If the last byte completes on the same cycle the timeout would expire, completion SHALL win.
REQ-033 A start-bit glitch (rx high at tick 7) SHALL return RX to idle with no byte counted.

Reset
REQ-034 Reset SHALL force state IDLE, tx=1, busy=0, resp_valid=0, timeout=0, resp_data=0, and clear all counters and shift registers.
REQ-035 Reset mid-frame SHALL drive tx high on the next cycle, with no partial frame resumed.

Verification
REQ-036 Reset, then idle 1000 cycles -> tx=1, busy=0, no pulses.
REQ-037 Defaults, start with req_data=0xA1B2C3D4 -> tx carries frames 0xA1, 0xB2, 0xC3, 0xD4; each frame is 2240 cycles; first start bit begins within 2 ticks of start.
REQ-038 Loopback model replies 0x11,0x22,0x33,0x44 -> one resp_valid pulse, resp_data=0x11223344, busy=0 the next cycle.
REQ-039 TIMEOUT_TICKS=100 and only 2 reply bytes -> timeout pulses 100 ticks after byte 2; resp_data keeps its prior value; no resp_valid.
REQ-040 start re-pulsed during SEND, and reset asserted mid-byte-2 -> the second start has no effect; after reset tx=1, busy=0, and a new start sends the full 4 bytes.
REQ-041 A 3-tick low glitch on rx in WAIT_RESP -> no byte counted; a following valid 4-byte reply completes normally.

Source files
------------

// File: rtl/uart_word_initiator.sv
// UART request/response initiator: shifts a multi-byte request out on tx as
// back-to-back 8N1 frames, then collects a fixed-length reply on rx with an idle timeout.
module uart_word_initiator #(
  parameter int DBITS         = 8,
  parameter int SB_TICK       = 16,
  parameter int BR_LIMIT      = 14,
  parameter int BR_BITS       = $clog2(BR_LIMIT),
  parameter int REQ_BYTES     = 4,
  parameter int RESP_BYTES    = 4,
  parameter int TIMEOUT_TICKS = 65535
) (
  input  logic                          clk_100MHz,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DBITS*REQ_BYTES-1:0]    req_data,
  output logic                          tx,
  input  logic                          rx,
  output logic                          busy,
  output logic                          resp_valid,
  output logic [DBITS*RESP_BYTES-1:0]   resp_data,
  output logic                          timeout
);

  localparam int REQ_W  = DBITS * REQ_BYTES;
  localparam int RESP_W = DBITS * RESP_BYTES;
  localparam int S_MAX  = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int S_W    = $clog2(S_MAX);
  localparam int N_W    = $clog2(DBITS + 1);
  localparam int B_MAX  = (REQ_BYTES > RESP_BYTES) ? REQ_BYTES : RESP_BYTES;
  localparam int BYTE_W = $clog2(B_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, DONE} state_t;
  typedef enum logic [1:0] {TX_START, TX_DATA, TX_STOP} tx_phase_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_phase_t;

  state_t              state, state_next;
  tx_phase_t           tx_phase;
  rx_phase_t           rx_phase;
  logic [BR_BITS-1:0]  br_cnt;
  logic                tick;
  logic [S_W-1:0]      tx_s, rx_s;
  logic [N_W-1:0]      tx_n, rx_n;
  logic [BYTE_W-1:0]   tx_idx, rx_cnt;
  logic [DBITS-1:0]    tx_bits, rx_bits;
  logic [REQ_W-1:0]    tx_word;
  logic [RESP_W-1:0]   resp_shreg, resp_shift;
  logic [TO_W-1:0]     to_cnt;
  logic                rx_q, rx_qq, rx_fall;
  logic                tx_frame_end, rx_done, to_expire, enter_wait;

  // Free-running oversampling tick shared by transmitter and receiver.
  always_ff @(posedge clk_100MHz) begin
    if (reset || tick) br_cnt <= '0;
    else               br_cnt <= br_cnt + BR_BITS'(1);
  end
  assign tick = (br_cnt == BR_BITS'(BR_LIMIT - 1));

  assign tx_frame_end = tick && (tx_phase == TX_STOP) && (tx_s == S_W'(SB_TICK - 1));
  assign rx_done      = tick && (rx_phase == RX_STOP) && (rx_s == S_W'(SB_TICK - 1));
  // The wait budget counts only ticks during which no frame is arriving.
  assign to_expire    = tick && (rx_phase == RX_IDLE) && (to_cnt >= TO_W'(TIMEOUT_TICKS - 1));
  assign resp_shift   = (resp_shreg << DBITS) | RESP_W'(rx_bits);
  assign enter_wait   = (state == SEND) && (state_next == WAIT_RESP);

  always_ff @(posedge clk_100MHz) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    resp_valid = (state == DONE);
    tx         = 1'b1;
    case (state)
      IDLE:      if (start) state_next = SEND;
      SEND: begin
        if (tx_phase == TX_START)     tx = 1'b0;
        else if (tx_phase == TX_DATA) tx = tx_bits[0];
        if (tx_frame_end && (tx_idx == BYTE_W'(REQ_BYTES - 1))) state_next = WAIT_RESP;
      end
      WAIT_RESP: begin
        // A completing last byte takes priority over an expiring wait.
        if (rx_done && (rx_cnt == BYTE_W'(RESP_BYTES - 1))) state_next = DONE;
        else if (to_expire)                                  state_next = IDLE;
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Transmitter: tx_bits holds the frame in flight, tx_word the bytes still queued.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      tx_phase <= TX_START;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_idx   <= '0;
      tx_bits  <= '0;
      tx_word  <= '0;
    end else if (state == IDLE && start) begin
      tx_phase <= TX_START;
      tx_s     <= '0;
      tx_n     <= '0;
      tx_idx   <= '0;
      tx_bits  <= req_data[REQ_W-1 -: DBITS];
      tx_word  <= req_data << DBITS;
    end else if (state == SEND && tick) begin
      case (tx_phase)
        TX_START: begin
          if (tx_s == S_W'(15)) begin
            tx_s     <= '0;
            tx_n     <= '0;
            tx_phase <= TX_DATA;
          end else tx_s <= tx_s + S_W'(1);
        end
        TX_DATA: begin
          if (tx_s == S_W'(15)) begin
            tx_s    <= '0;
            tx_bits <= tx_bits >> 1;
            if (tx_n == N_W'(DBITS - 1)) tx_phase <= TX_STOP;
            else                         tx_n     <= tx_n + N_W'(1);
          end else tx_s <= tx_s + S_W'(1);
        end
        default: begin
          if (tx_s == S_W'(SB_TICK - 1)) begin
            tx_s     <= '0;
            tx_phase <= TX_START;
            tx_idx   <= tx_idx + BYTE_W'(1);
            tx_bits  <= tx_word[REQ_W-1 -: DBITS];
            tx_word  <= tx_word << DBITS;
          end else tx_s <= tx_s + S_W'(1);
        end
      endcase
    end
  end

  // Receiver: the start bit is re-checked near its middle, data then sampled every 16 ticks.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rx_q     <= 1'b1;
      rx_qq    <= 1'b1;
      rx_phase <= RX_IDLE;
      rx_s     <= '0;
      rx_n     <= '0;
      rx_bits  <= '0;
    end else begin
      rx_q  <= rx;
      rx_qq <= rx_q;
      case (rx_phase)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_s     <= '0;
            rx_phase <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_s == S_W'(7)) begin
              rx_s     <= '0;
              rx_n     <= '0;
              rx_phase <= rx_q ? RX_IDLE : RX_DATA;
            end else rx_s <= rx_s + S_W'(1);
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_s == S_W'(15)) begin
              rx_s    <= '0;
              rx_bits <= {rx_q, rx_bits[DBITS-1:1]};
              if (rx_n == N_W'(DBITS - 1)) rx_phase <= RX_STOP;
              else                         rx_n     <= rx_n + N_W'(1);
            end else rx_s <= rx_s + S_W'(1);
          end
        end
        default: begin
          if (tick) begin
            if (rx_s == S_W'(SB_TICK - 1)) begin
              rx_s     <= '0;
              rx_phase <= RX_IDLE;
            end else rx_s <= rx_s + S_W'(1);
          end
        end
      endcase
    end
  end
  assign rx_fall = rx_qq & ~rx_q;

  // Response assembly and wait supervision; bytes outside WAIT_RESP are dropped.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      resp_shreg <= '0;
      resp_data  <= '0;
      rx_cnt     <= '0;
      to_cnt     <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= (state == WAIT_RESP) && (state_next == IDLE);
      if (state == IDLE && start) begin
        rx_cnt <= '0;
        to_cnt <= '0;
      end else if (enter_wait) begin
        resp_shreg <= '0;
        rx_cnt     <= '0;
      end else if (state == WAIT_RESP) begin
        if (rx_done) begin
          resp_shreg <= resp_shift;
          rx_cnt     <= rx_cnt + BYTE_W'(1);
          to_cnt     <= '0;
          if (rx_cnt == BYTE_W'(RESP_BYTES - 1)) resp_data <= resp_shift;
        end else if (tick && rx_phase == RX_IDLE && to_cnt < TO_W'(TIMEOUT_TICKS)) begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_word_initiator.sv
// Directed-plus-random bench for uart_word_initiator: decodes tx frames, drives rx replies,
// and compares against byte-level expectations derived from the request/reply words.
module tb_uart_word_initiator;
  localparam int BR_LIMIT  = 14;
  localparam int BIT_CYC   = 16 * BR_LIMIT;
  localparam int FRAME_CYC = 10 * BIT_CYC;
  localparam int TO_TICKS  = 100;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1, start = 1'b0, rx = 1'b1;
  logic [31:0] req_data = '0;
  logic        tx, busy, resp_valid, timeout;
  logic [31:0] resp_data;

  int total = 0, bad = 0, cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int fall_q[$];
  int rv_seen = 0, to_seen = 0, to_cyc = 0;
  logic [31:0] rv_data = '0;
  logic busy_after_rv = 1'bx;

  uart_word_initiator #(.TIMEOUT_TICKS(TO_TICKS)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .start(start), .req_data(req_data),
    .tx(tx), .rx(rx), .busy(busy), .resp_valid(resp_valid),
    .resp_data(resp_data), .timeout(timeout)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  initial forever begin
    @(posedge clk_100MHz);
    cyc++;
  end

  // tx decoder: one byte per falling edge, sampling each bit in its middle.
  initial begin : tx_mon
    logic prev;
    logic [7:0] b;
    prev = 1'b1;
    forever begin
      @(negedge clk_100MHz);
      if (prev === 1'b1 && tx === 1'b0) begin
        fall_q.push_back(cyc);
        repeat (BIT_CYC / 2) @(negedge clk_100MHz);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYC) @(negedge clk_100MHz);
          b[i] = tx;
        end
        got_q.push_back(b);
      end
      prev = tx;
    end
  end

  initial begin : pulse_mon
    logic rv_prev;
    rv_prev = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      if (rv_prev) busy_after_rv = busy;
      if (resp_valid === 1'b1) begin
        rv_seen++;
        rv_data = resp_data;
      end
      if (timeout === 1'b1) begin
        to_seen++;
        to_cyc = cyc;
      end
      rv_prev = (resp_valid === 1'b1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic pulse_start(input logic [31:0] d);
    req_data = d;
    start = 1'b1;
    @(negedge clk_100MHz);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    tick_n(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick_n(BIT_CYC);
    end
    rx = 1'b1;
    tick_n(BIT_CYC);
  endtask

  task automatic wait_frames(input int n, input string tag);
    int waited;
    waited = 0;
    while (got_q.size() < n && waited < 4 * FRAME_CYC + 2000) begin
      @(negedge clk_100MHz);
      waited++;
    end
    check(tag, 32'(got_q.size() >= n), 32'd1);
  endtask

  // Expected wire order: request word split into bytes, most significant first.
  task automatic check_frames(input logic [31:0] req, input string tag);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'((req >> (8 * (3 - k))) & 32'hFF));
    for (int k = 0; k < 4; k++) begin
      if (got_q.size() > 0) check($sformatf("%s_b%0d", tag, k), 32'(got_q.pop_front()), 32'(exp_q[0]));
      else                  check($sformatf("%s_b%0d_missing", tag, k), 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic wait_count(input int target, input bit want_to, input int budget, input string tag);
    int waited;
    waited = 0;
    while (((want_to ? to_seen : rv_seen) < target) && waited < budget) begin
      @(negedge clk_100MHz);
      waited++;
    end
    check(tag, 32'((want_to ? to_seen : rv_seen) >= target), 32'd1);
  endtask

  initial begin
    int tx_low, busy_hi, st_cyc, lat, rv0, to0, t0, delta;
    logic [31:0] r, exp_resp;
    logic [7:0] rb;

    // Reset and idle
    tick_n(3);
    reset = 1'b0;
    @(negedge clk_100MHz);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    tx_low = 0;
    busy_hi = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk_100MHz);
      if (tx !== 1'b1) tx_low++;
      if (busy !== 1'b0) busy_hi++;
    end
    check("idle_tx_low_cycles", 32'(tx_low), 32'd0);
    check("idle_busy_cycles", 32'(busy_hi), 32'd0);
    check("idle_pulses", 32'(rv_seen + to_seen), 32'd0);

    // Directed request with a stray start during SEND, then a full reply
    got_q.delete();
    fall_q.delete();
    check("pre_busy", 32'(busy), 32'd0);
    st_cyc = cyc;
    pulse_start(32'hA1B2C3D4);
    check("busy_rise", 32'(busy), 32'd1);
    tick_n(500);
    pulse_start(32'h0BADF00D);
    check("busy_hold", 32'(busy), 32'd1);
    wait_frames(4, "dir_frames_seen");
    lat = (fall_q.size() > 0) ? fall_q[0] - st_cyc : -1;
    check("first_start_latency", 32'(lat >= 0 && lat <= 2 * BR_LIMIT), 32'd1);
    if (fall_q.size() >= 4) begin
      check("frame0_len", 32'((fall_q[1] - fall_q[0]) > FRAME_CYC - BR_LIMIT &&
                              (fall_q[1] - fall_q[0]) <= FRAME_CYC), 32'd1);
      check("frame1_len", 32'(fall_q[2] - fall_q[1]), 32'(FRAME_CYC));
      check("frame2_len", 32'(fall_q[3] - fall_q[2]), 32'(FRAME_CYC));
    end else check("frame_edges", 32'(fall_q.size()), 32'd4);
    check_frames(32'hA1B2C3D4, "dir_tx");
    tick_n(400);
    rv0 = rv_seen;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    wait_count(rv0 + 1, 1'b0, 3000, "dir_resp_seen");
    tick_n(5);
    check("dir_resp_pulses", 32'(rv_seen - rv0), 32'd1);
    check("dir_rv_data", rv_data, 32'h11223344);
    check("dir_resp_data", resp_data, 32'h11223344);
    check("dir_busy_after", 32'(busy_after_rv), 32'd0);
    check("dir_no_timeout", 32'(to_seen), 32'd0);

    // Two reply bytes only: expect a timeout 100 idle ticks after the second completes
    got_q.delete();
    r = $urandom;
    rv0 = rv_seen;
    to0 = to_seen;
    pulse_start(r);
    wait_frames(4, "to_frames_seen");
    check_frames(r, "to_tx");
    tick_n(400);
    send_byte(8'($urandom_range(0, 255)));
    t0 = cyc;
    send_byte(8'($urandom_range(0, 255)));
    wait_count(to0 + 1, 1'b1, 3000, "to_seen");
    tick_n(3);
    delta = to_cyc - t0;
    check("to_delay", 32'(delta >= 3500 && delta <= 3556), 32'd1);
    check("to_pulses", 32'(to_seen - to0), 32'd1);
    check("to_resp_data_kept", resp_data, 32'h11223344);
    check("to_no_resp_valid", 32'(rv_seen - rv0), 32'd0);
    check("to_busy", 32'(busy), 32'd0);

    // Random request, rx glitch in WAIT_RESP, then random 4-byte reply
    got_q.delete();
    r = $urandom;
    rv0 = rv_seen;
    to0 = to_seen;
    pulse_start(r);
    wait_frames(4, "gl_frames_seen");
    check_frames(r, "gl_tx");
    tick_n(400);
    rx = 1'b0;
    tick_n(3 * BR_LIMIT);
    rx = 1'b1;
    tick_n(200);
    exp_resp = '0;
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom_range(0, 255));
      exp_resp = (exp_resp << 8) | 32'(rb);
      send_byte(rb);
    end
    wait_count(rv0 + 1, 1'b0, 3000, "gl_resp_seen");
    tick_n(5);
    check("gl_resp_pulses", 32'(rv_seen - rv0), 32'd1);
    check("gl_resp_data", resp_data, exp_resp);
    check("gl_no_timeout", 32'(to_seen - to0), 32'd0);

    // Reset during the second byte, then a fresh request runs in full
    got_q.delete();
    r = $urandom;
    pulse_start(r);
    wait_frames(1, "rst_frame1_seen");
    tick_n(600);
    reset = 1'b1;
    @(negedge clk_100MHz);
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_resp_data", resp_data, 32'd0);
    reset = 1'b0;
    if (got_q.size() > 0) check("mid_rst_byte1", 32'(got_q[0]), 32'((r >> 24) & 32'hFF));
    else                  check("mid_rst_byte1_missing", 32'd0, 32'd1);
    tx_low = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk_100MHz);
      if (tx !== 1'b1) tx_low++;
    end
    check("post_rst_tx_idle", 32'(tx_low), 32'd0);
    got_q.delete();
    fall_q.delete();
    r = $urandom;
    to0 = to_seen;
    pulse_start(r);
    wait_frames(4, "post_rst_frames_seen");
    check_frames(r, "post_rst_tx");
    wait_count(to0 + 1, 1'b1, 3000, "post_rst_timeout");
    tick_n(3);
    check("post_rst_resp_data", resp_data, 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
